fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO. Successor to the fixed 10-deep 8-bit FIFO.
//  Storage is a register bank. Writes go to one row, selected by a parametrised one-hot address decoder.
//  Adds occupancy count, almost-full/almost-empty flags, registered read data with valid, and overflow/underflow pulses.
//  Sits between producer and consumer datapaths in the same clock domain.
// PARAMETERS
//  WIDTH      8   data word width in bits (>=1)
//  DEPTH      10  number of entries (>=2, need not be a power of 2)
//  AFULL_TH   8   almost_full asserts when count >= AFULL_TH (1..DEPTH)
//  AEMPTY_TH  2   almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1)
//  (derived) AW = $clog2(DEPTH) pointer width; CW = $clog2(DEPTH+1) count width
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  wr_en         in   1      write request
//  wr_data       in   WIDTH  write data, sampled with wr_en
//  rd_en         in   1      read request
//  rd_data       out  WIDTH  read data, registered
//  rd_valid      out  1      rd_data holds a newly popped word this cycle
//  full          out  1      count == DEPTH
//  empty         out  1      count == 0
//  almost_full   out  1      count >= AFULL_TH
//  almost_empty  out  1      count <= AEMPTY_TH
//  count         out  CW     current occupancy, 0..DEPTH
//  overflow      out  1      1-cycle pulse: wr_en while full (write dropped)
//  underflow     out  1      1-cycle pulse: rd_en while empty (read dropped)
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync-released by clk):
//    wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
//    Resulting flags: empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0 ? 1 : 0).
//    Storage rows are NOT reset. Reset mid-operation discards all contents immediately.
//  - Write accept: wr_acc = wr_en & ~full, evaluated on pre-edge state.
//    Decoder input = wr_ptr, enable = wr_acc. Exactly one row loads wr_data on the edge.
//  - Read accept: rd_acc = rd_en & ~empty, evaluated on pre-edge state.
//    On the edge, rd_data <= mem[rd_ptr] and rd_valid <= 1.
//    Read latency is 1 cycle. rd_valid=0 on any cycle without rd_acc. rd_data holds its last value.
//  - Pointers advance by 1 on accept and wrap DEPTH-1 -> 0 (explicit compare, not modulo 2^AW).
//  - count: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
//  - Simultaneous wr_en & rd_en:
//    - neither full nor empty: both accepted, count unchanged.
//    - full: read accepted, write dropped, overflow pulses.
//    - empty: write accepted, read dropped, underflow pulses. No write-to-read bypass.
//  - Flags are combinational decodes of the registered count. They update the cycle after the accept.
//  - overflow/underflow are registered, high for exactly 1 cycle per offending request. Pointers and count are untouched.
//  - Decoder rows >= DEPTH (when DEPTH is not a power of 2) are unreachable and unconnected.
// STRUCTURE
//  - Shared package fifo_pkg: localparam function for CW/AW (clog2), default WIDTH/DEPTH constants.
//  - Sub-module decoder_n #(N=AW, OUTS=DEPTH): enable-gated binary-to-one-hot decoder.
//    Combinational; zero outputs when enable=0. Replaces the fixed 2-to-4 decoder.
//  - Top: pointer/count registers, register bank (DEPTH x WIDTH), read mux, flag logic, error pulse regs.
// TESTING
//  1. Reset, then idle 3 cycles -> empty=1, count=0, rd_valid=0, almost_empty=1, full=0.
//  2. Write 0x01..0x0A (10 words, default params) -> full=1 and count=10 after 10th edge;
//     almost_full first high after 8th write. Then read 10 -> rd_data 0x01..0x0A in order, 1-cycle latency.
//  3. When full, pulse wr_en with 0xFF -> overflow=1 for 1 cycle, count stays 10,
//     0xFF never appears on rd_data.
//  4. When empty, pulse rd_en -> underflow=1 for 1 cycle, rd_valid=0, count stays 0.
//  5. Hold count=5, assert wr_en+rd_en for 20 cycles -> count stays 5; both pointers wrap 9->0 twice;
//     output order is preserved.
//  6. With count=6 mid-stream, drop rst_n asynchronously between edges -> outputs go to reset values
//     without waiting for a clock edge. Then write 0xA5, read -> rd_data=0xA5.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 10;
  localparam int unsigned DEF_AFULL_TH  = 8;
  localparam int unsigned DEF_AEMPTY_TH = 2;

  // Ceiling log2, usable in parameter/localparam elaboration.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2_f(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2_f(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer-facing signal bundle of the synchronous FIFO.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  // Datapath side that pushes and pops words.
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  // The FIFO itself.
  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/decoder_n.sv
// Enable-gated binary-to-one-hot decoder; only the first OUTS codes have rows.
module decoder_n #(
  parameter int unsigned N    = 4,
  parameter int unsigned OUTS = 10
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  output logic [OUTS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < OUTS; i++) begin
      if (sel == N'(i)) begin
        onehot[i] = en;
      end
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO on a register bank with occupancy flags, registered read
// data and overflow/underflow pulses.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AFULL_TH  = DEF_AFULL_TH,
  parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_param_if.slave bus
);

  localparam int unsigned AW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] row_we;

  logic full_c;
  logic empty_c;
  logic wr_acc;
  logic rd_acc;

  // Pointers wrap at DEPTH-1 so non-power-of-2 depths use every row.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_c  = (cnt == CW'(DEPTH));
  assign empty_c = (cnt == '0);
  assign wr_acc  = bus.wr_en & ~full_c;
  assign rd_acc  = bus.rd_en & ~empty_c;

  decoder_n #(
    .N    (AW),
    .OUTS (DEPTH)
  ) u_wr_dec (
    .sel    (wr_ptr),
    .en     (wr_acc),
    .onehot (row_we)
  );

  // Storage rows are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (row_we[i]) begin
        mem[i] <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (wr_acc && !rd_acc) begin
        cnt <= cnt + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Read port and error pulses; a write into an empty FIFO is never bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_valid_q  <= rd_acc;
      overflow_q  <= bus.wr_en & full_c;
      underflow_q <= bus.rd_en & empty_c;
      if (rd_acc) begin
        rd_data_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.count        = cnt;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (cnt >= CW'(AFULL_TH));
  assign bus.almost_empty = (cnt <= CW'(AEMPTY_TH));

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: directed scenarios plus random traffic against a queue model.
module tb_fifo_sync_param;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 10;
  localparam int unsigned AF = 8;
  localparam int unsigned AE = 2;

  logic clk;
  logic rst_n;

  fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_sync_param #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AFULL_TH  (AF),
    .AEMPTY_TH (AE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       n_checks;
  int       n_pass;
  int       q[$];
  bit [7:0] exp_data;
  bit       exp_valid;
  bit       exp_ovf;
  bit       exp_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"},        32'(bus.count),        32'(n));
    check({tag, ".full"},         32'(bus.full),         32'(n == D));
    check({tag, ".empty"},        32'(bus.empty),        32'(n == 0));
    check({tag, ".almost_full"},  32'(bus.almost_full),  32'(n >= AF));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
    check({tag, ".rd_valid"},     32'(bus.rd_valid),     32'(exp_valid));
    check({tag, ".rd_data"},      32'(bus.rd_data),      32'(exp_data));
    check({tag, ".overflow"},     32'(bus.overflow),     32'(exp_ovf));
    check({tag, ".underflow"},    32'(bus.underflow),    32'(exp_unf));
  endtask

  // One clock: apply request on the falling edge, predict, check after the rising edge.
  task automatic cycle(input string tag, input bit we, input bit [7:0] wd, input bit re);
    int pre;
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    pre       = q.size();
    exp_ovf   = we && (pre == D);
    exp_unf   = re && (pre == 0);
    exp_valid = re && (pre > 0);
    if (exp_valid) exp_data = 8'(q.pop_front());
    if (we && pre < D) q.push_back(int'(wd));
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    model_reset();

    // Power-on reset and idle.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("reset");
    for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 8'h00, 1'b0);

    // Fill with 0x01..0x0A, overflow attempt, then drain in order.
    for (int i = 1; i <= 10; i++) cycle("fill", 1'b1, 8'(i), 1'b0);
    cycle("overflow", 1'b1, 8'hFF, 1'b0);
    cycle("post_ovf", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) cycle("drain", 1'b0, 8'h00, 1'b1);

    // Underflow attempt on empty FIFO.
    cycle("underflow", 1'b0, 8'h00, 1'b1);
    cycle("post_unf", 1'b0, 8'h00, 1'b0);

    // Steady count of 5 with simultaneous traffic, pointers wrap twice.
    for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle("both", 1'b1, 8'($urandom), 1'b1);

    // Random traffic at several write/read biases.
    for (int seg = 0; seg < 4; seg++) begin
      int wp;
      int rp;
      wp = 20 + seg * 20;
      rp = 80 - seg * 20;
      for (int i = 0; i < 100; i++)
        cycle("rand", ($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) < rp));
    end

    // Write and read simultaneously while empty: no bypass.
    for (int i = 0; i < D && q.size() > 0; i++) cycle("empty_out", 1'b0, 8'h00, 1'b1);
    cycle("wr_rd_empty", 1'b1, 8'h5C, 1'b1);
    cycle("wr_rd_empty2", 1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-stream at count 6.
    for (int i = 0; i < 6; i++) cycle("pre6", 1'b1, 8'(8'h60 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    rst_n     = 1'b1;
    cycle("rst_idle", 1'b0, 8'h00, 1'b0);
    cycle("wr_a5", 1'b1, 8'hA5, 1'b0);
    cycle("rd_a5", 1'b0, 8'h00, 1'b1);
    cycle("tail", 1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
